// File: rtl/ult_ranger_if.sv
// rtl/ult_ranger_if.sv - result bus from the ranger to the seven-segment display mux
//
// Purpose: carries the latched 4-digit BCD distance and its status flags.
// Members:
//   count_one/ten/hundred/thousand  BCD millimetre digits, stable between measurements
//   valid                            one-cycle pulse when a measurement completes
//   err                              last measurement timed out waiting for echo
//   ovr                              last measurement saturated at MAX_MM
// Modports: master = ranger (drives), slave = display stage (reads).

interface ult_ranger_if;
  logic [3:0] count_one;
  logic [3:0] count_ten;
  logic [3:0] count_hundred;
  logic [3:0] count_thousand;
  logic       valid;
  logic       err;
  logic       ovr;

  modport master (
    output count_one, count_ten, count_hundred, count_thousand, valid, err, ovr
  );

  modport slave (
    input count_one, count_ten, count_hundred, count_thousand, valid, err, ovr
  );
endinterface

// File: rtl/ult_ranger.sv
// rtl/ult_ranger.sv - single-wire ultrasonic ranger with BCD millimetre output
//
// Purpose: periodically triggers the sensor over the shared sig pin, times the
// returned echo and reports its width as millimetres in 4-digit BCD.
// Ports:
//   clk  system clock (12 MHz nominal)
//   rst  synchronous reset, active-high
//   sig  bidirectional sensor pin: driven 1 during trigger, otherwise high-Z
//   res  result bus (ult_ranger_if.master): BCD digits, valid, err, ovr

module ult_ranger #(
  parameter int unsigned TRIG_CYC   = 120,
  parameter int unsigned CYC_PER_MM = 70,
  parameter int unsigned WAIT_CYC   = 360000,
  parameter int unsigned MAX_MM     = 4000,
  parameter int unsigned PERIOD_CYC = 720000
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire           sig,
  ult_ranger_if.master  res
);

  localparam int unsigned CNT_MAX = (WAIT_CYC > TRIG_CYC) ? WAIT_CYC : TRIG_CYC;
  localparam int CW  = $clog2(CNT_MAX) + 1;
  localparam int PCW = $clog2(PERIOD_CYC) + 1;
  localparam int PSW = $clog2(CYC_PER_MM) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    RELEASE = 3'd2,
    ECHO    = 3'd3,
    DONE    = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t state, state_nx;

  // Input synchroniser plus one delayed copy for edge detection
  logic sig_m, sig_s, sig_q;
  logic rise, fall;

  logic [CW-1:0]  cnt;       // trigger length / echo wait budget
  logic [PCW-1:0] pcnt;      // period counter, restarts on entry to TRIG
  logic [PSW-1:0] presc;     // cycles within the current millimetre
  logic [13:0]    mm_bin;    // binary shadow of the BCD count for compare
  logic [3:0]     d0, d1, d2, d3;
  logic [3:0]     d0_nx, d1_nx, d2_nx, d3_nx;
  logic           seen_low;  // echo line observed low since release
  logic           to_flag, ov_flag;

  // Strobes from the next-state logic
  logic echo_start, mm_wrap, to_set, ov_set;
  logic drive;

  assign drive = (state == TRIG);
  assign sig   = drive ? 1'b1 : 1'bz;

  assign rise = sig_s & ~sig_q;
  assign fall = ~sig_s & sig_q;

  // BCD increment with cascaded carries; the top digit never passes 9
  // because MAX_MM <= 9999 stops counting first.
  always_comb begin
    d0_nx = d0;
    d1_nx = d1;
    d2_nx = d2;
    d3_nx = d3;
    if (d0 == 4'd9) begin
      d0_nx = 4'd0;
      if (d1 == 4'd9) begin
        d1_nx = 4'd0;
        if (d2 == 4'd9) begin
          d2_nx = 4'd0;
          d3_nx = d3 + 4'd1;
        end else begin
          d2_nx = d2 + 4'd1;
        end
      end else begin
        d1_nx = d1 + 4'd1;
      end
    end else begin
      d0_nx = d0 + 4'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    echo_start = 1'b0;
    to_set     = 1'b0;
    ov_set     = 1'b0;
    mm_wrap    = (state == ECHO) && (presc == PSW'(CYC_PER_MM - 1));
    case (state)
      IDLE: state_nx = TRIG;
      TRIG: begin
        if (cnt == CW'(TRIG_CYC - 1)) state_nx = RELEASE;
      end
      RELEASE: begin
        // A rise only counts once the line has been seen low after release,
        // so an echo stuck high from before is ignored.
        if (seen_low && rise) begin
          state_nx   = ECHO;
          echo_start = 1'b1;
        end else if (cnt == CW'(WAIT_CYC - 1)) begin
          state_nx = DONE;
          to_set   = 1'b1;
        end
      end
      ECHO: begin
        // Saturation wins over a simultaneous falling edge.
        if (mm_wrap && (mm_bin == 14'(MAX_MM - 1))) begin
          state_nx = DONE;
          ov_set   = 1'b1;
        end else if (fall) begin
          state_nx = DONE;
        end
      end
      DONE: state_nx = HOLD;
      HOLD: begin
        if (pcnt == PCW'(PERIOD_CYC - 1)) state_nx = TRIG;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      sig_m              <= 1'b0;
      sig_s              <= 1'b0;
      sig_q              <= 1'b0;
      cnt                <= '0;
      pcnt               <= '0;
      presc              <= '0;
      mm_bin             <= '0;
      d0                 <= 4'd0;
      d1                 <= 4'd0;
      d2                 <= 4'd0;
      d3                 <= 4'd0;
      seen_low           <= 1'b0;
      to_flag            <= 1'b0;
      ov_flag            <= 1'b0;
      res.count_one      <= 4'd0;
      res.count_ten      <= 4'd0;
      res.count_hundred  <= 4'd0;
      res.count_thousand <= 4'd0;
      res.valid          <= 1'b0;
      res.err            <= 1'b0;
      res.ovr            <= 1'b0;
    end else begin
      state <= state_nx;
      sig_m <= sig;
      sig_s <= sig_m;
      sig_q <= sig_s;

      if ((state_nx == TRIG) && (state != TRIG)) pcnt <= '0;
      else                                       pcnt <= pcnt + PCW'(1);

      if (state_nx != state)                          cnt <= '0;
      else if ((state == TRIG) || (state == RELEASE)) cnt <= cnt + CW'(1);

      if (state != RELEASE) seen_low <= 1'b0;
      else if (!sig_s)      seen_low <= 1'b1;

      if (echo_start) begin
        presc  <= '0;
        mm_bin <= '0;
        d0     <= 4'd0;
        d1     <= 4'd0;
        d2     <= 4'd0;
        d3     <= 4'd0;
      end else if (state == ECHO) begin
        if (mm_wrap) begin
          presc  <= '0;
          mm_bin <= mm_bin + 14'd1;
          d0     <= d0_nx;
          d1     <= d1_nx;
          d2     <= d2_nx;
          d3     <= d3_nx;
        end else begin
          presc <= presc + PSW'(1);
        end
      end

      // Flags are captured on the cycle that enters DONE and consumed in DONE.
      to_flag <= to_set;
      ov_flag <= ov_set;

      res.valid <= (state == DONE);
      if (state == DONE) begin
        if (to_flag) begin
          res.err <= 1'b1;
          res.ovr <= 1'b0;
        end else begin
          // On saturation the counter already holds MAX_MM.
          res.count_one      <= d0;
          res.count_ten      <= d1;
          res.count_hundred  <= d2;
          res.count_thousand <= d3;
          res.err            <= 1'b0;
          res.ovr            <= ov_flag;
        end
      end
    end
  end

endmodule

// File: doc/ult_ranger.md
Name: ult_ranger

Overview:
Single-wire ultrasonic ranging front end, sitting directly upstream of the 4-digit seven-segment display mux.
- Periodically drives a trigger pulse onto the shared bidirectional sig pin, then releases it.
- Times the returned echo pulse and converts its width to millimetres in 4-digit BCD.
- Holds the last result stable for the display stage between measurements.

Parameters:
TRIG_CYC, 120, trigger high time in clk cycles (10 us at 12 MHz)
CYC_PER_MM, 70, clk cycles of echo width per 1 mm of distance (round trip, 343 m/s)
WAIT_CYC, 360000, maximum cycles from sig release to echo rising edge (30 ms)
MAX_MM, 4000, saturation distance in mm (must be <= 9999)
PERIOD_CYC, 720000, cycles from one trigger start to the next (60 ms); must be > TRIG_CYC+WAIT_CYC+MAX_MM*CYC_PER_MM+8

Ports:
clk  input  1  system clock, 12 MHz
rst  input  1  synchronous reset, active-high
sig  inout  1  sensor pin; driven 1 during trigger, else high-Z
count_one  output  4  BCD mm units
count_ten  output  4  BCD mm tens
count_hundred  output  4  BCD mm hundreds
count_thousand  output  4  BCD mm thousands
valid  output  1  one-cycle pulse when a measurement completes
err  output  1  registered; 1 = last measurement timed out waiting for echo
ovr  output  1  registered; 1 = last measurement saturated at MAX_MM

Behaviour:
- The only clock is clk. rst is synchronous and active-high, and everything samples on the rising edge.
- Reset values: sig high-Z, all count_* = 0, valid = 0, err = 0, ovr = 0, state = IDLE, all counters 0.
- Reset asserted mid-operation releases sig at that edge and aborts the measurement. Outputs go to their reset values.
- Input path: sig passes through a 2-FF synchroniser, giving sig_s. Edges are detected on sig_s against a registered copy, so edge detection lags the pin by 2 cycles.
- A free-running period counter restarts at 0 on entry to TRIG.
- States:
  - IDLE: one cycle after reset release, then TRIG.
  - TRIG: sig driven 1 for exactly TRIG_CYC cycles, then RELEASE.
  - RELEASE: sig high-Z. First wait for sig_s = 0, then for a sig_s rising edge. A rising edge goes to ECHO with the mm BCD counter and the prescaler cleared. If the WAIT_CYC budget expires first, go to DONE with timeout flagged.
  - ECHO: the prescaler counts 0..CYC_PER_MM-1. On each wrap the mm count increments (4-digit BCD with cascaded carries, plus a binary shadow for compare). A sig_s falling edge goes to DONE. If the mm count reaches MAX_MM, stop counting, flag overflow, and go to DONE without waiting for the fall.
  - DONE: one cycle. Latch results and pulse valid, then HOLD.
  - HOLD: wait until the period counter equals PERIOD_CYC-1, then TRIG.
- Arithmetic: mm = floor(W / CYC_PER_MM), where W is the synchronised echo width in cycles. The partial-prescaler residue is discarded.
- Latch rules at DONE:
  - Normal end: count_* = BCD mm, err = 0, ovr = 0.
  - Saturation: count_* = BCD of MAX_MM, ovr = 1, err = 0.
  - Timeout: count_* unchanged, err = 1, ovr = 0.
- Outputs change only at DONE, so the digits are stable for a full period.
- Falling edge and saturation in the same cycle: ovr = 1 and count = MAX_MM.
- An echo already high at release is not measured until it goes low and rises again. This wait counts against WAIT_CYC.
- BCD wrap: 0999 -> 1000 in one cycle. Digits never exceed 9.

Test Plan:
- Reset, then a model asserts echo 500 cycles after release, high for 7000 cycles -> sig driven 1 for exactly 120 cycles; then valid pulses once with count_* = 0,1,0,0 (thousand..one); err = ovr = 0.
- Echo width 7069, then 7070 cycles -> 100 mm, then 101 mm (truncation boundary).
- No echo -> valid pulses 360000 cycles after release with err = 1; digits retain the previous 0100.
- Echo held high indefinitely -> at 4000 mm (280000 cycles) valid pulses with count 4,0,0,0 and ovr = 1; next trigger is still 720000 cycles after the previous one.
- Echo high at release (stuck), then low for 100 cycles, then a 6930-cycle pulse -> result 99 mm (0,0,9,9).
- rst asserted mid-ECHO -> sig high-Z on that edge, outputs zero, no valid pulse; a trigger restarts 2 cycles after rst deasserts; back-to-back triggers are PERIOD_CYC apart.
